// File: rtl/seq_ripple_adder.sv
// seq_ripple_adder: multi-cycle chunked ripple-carry adder/subtractor.
// Operands are latched on accept and summed CHUNK bits per clock, least
// significant chunk first, with the inter-chunk carry held in a register.
// Results are presented through a valid/ready handshake and held until taken.

module seq_ripple_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic             armed;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry;
    logic [IDXW-1:0]  index;

    int               base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_c;
    logic             chunk_ovf;
    logic             last;
    logic             accept;

    // armed keeps in_ready low until the first clock edge after reset is released
    assign in_ready  = (state == IDLE) && armed;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (index == LAST_IDX);

    // Current chunk slice and its ripple sum; overflow uses carry-into-MSB = a^b^s at the MSB
    always_comb begin
        base      = int'(index) * CHUNK;
        chunk_a   = a_reg[base +: CHUNK];
        chunk_b   = b_reg[base +: CHUNK];
        {chunk_c, chunk_s} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry};
        chunk_ovf = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_s[CHUNK-1] ^ chunk_c;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: accept in IDLE, step through chunks in RUN, wait for consumer in DONE
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on accept, accumulate one chunk per RUN cycle, capture flags on the last chunk
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            index <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg <= a;
                        b_reg <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        index <= '0;
                    end
                end
                RUN: begin
                    sum[base +: CHUNK] <= chunk_s;
                    carry <= chunk_c;
                    if (last) begin
                        cout  <= chunk_c;
                        ovf   <= chunk_ovf;
                        index <= '0;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
